// File: rtl/gmii_pkt_gen_pkg.sv
// gmii_pkt_pkg: shared FSM encodings, frame length limits and header layout for the frame generator.
package gmii_pkt_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [10:0] MIN_LEN = 11'd60;
  localparam logic [10:0] MAX_LEN = 11'd1514;
  // Header byte offsets: DST at 0, then SRC, ETHERTYPE, sequence number, payload.
  localparam int SRC_OFF  = 6;
  localparam int TYPE_OFF = SRC_OFF + 6;
  localparam int SEQ_OFF  = TYPE_OFF + 2;
  localparam int PAY_OFF  = SEQ_OFF + 4;
  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    return l < MIN_LEN ? MIN_LEN : l > MAX_LEN ? MAX_LEN : l;
  endfunction
endpackage

// File: rtl/gmii_pkt_gen_if.sv
// gmii_pkt_gen_if: byte stream towards the loopback buffer plus its almost-full back-pressure flag.
interface gmii_pkt_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       alf;
  modport master (output tdata, tvalid, tlast, tuser, input alf);
  modport slave (input tdata, tvalid, tlast, tuser, output alf);
endinterface

// File: rtl/gmii_pkt_byte_sel.sv
// gmii_pkt_byte_sel: combinational frame byte for index idx: header bytes, then idx ^ seq payload.
module gmii_pkt_byte_sel
  import gmii_pkt_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [10:0] idx,
  input  logic [31:0] seq,
  output logic [7:0]  data
);
  logic [8*PAY_OFF-1:0] hdr;
  logic [4:0] k;
  always_comb begin
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
    k = 5'(PAY_OFF - 1) - idx[4:0];
    data = idx < 11'(PAY_OFF) ? 8'(hdr >> {k, 3'b000}) : idx[7:0] ^ seq[7:0];
  end
endmodule

// File: rtl/gmii_pkt_gen.sv
// gmii_pkt_gen: test-frame source for the receive stream; starts frames only when the sink is not
// almost full, then sends one byte per cycle with a programmable inter-frame gap.
module gmii_pkt_gen
  import gmii_pkt_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        wrclk,
  input  logic        wr_reset,
  input  logic        gen_en,
  input  logic [10:0] frame_len,
  input  logic [7:0]  ifg,
  input  logic [15:0] burst_cnt,
  input  logic        err_inject,
  gmii_pkt_gen_if.master rx,
  output logic        gen_busy,
  output logic        gen_done,
  output logic [31:0] frame_cnt,
  output logic [31:0] holdoff_cnt
);
  logic [1:0]  state_q, state_d;
  logic [10:0] idx_q, idx_d, len_q, len_d;
  logic [7:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic [31:0] seq_q, seq_d, frame_cnt_q, frame_cnt_d, holdoff_q, holdoff_d;
  logic [15:0] sent_q, sent_d, burst_q, burst_d;
  logic        err_q, err_d, pend_q, pend_d;
  logic [7:0]  tdata_q, tdata_d, byte_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        busy_q, busy_d, done_q, done_d, try_start;

  gmii_pkt_byte_sel #(.DST_MAC(DST_MAC), .SRC_MAC(SRC_MAC), .ETHERTYPE(ETHERTYPE)) u_sel (
    .idx (idx_d),
    .seq (seq_q),
    .data(byte_d)
  );

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    seq_d = seq_q;
    sent_d = sent_q;
    burst_d = burst_q;
    err_d = err_q;
    pend_d = pend_q | err_inject;
    frame_cnt_d = frame_cnt_q;
    holdoff_d = holdoff_q;
    try_start = 1'b0;
    if (state_q == ST_SEND) begin
      if (idx_q == len_q - 11'd1) begin
        state_d = ST_GAP;
        gcnt_d = 8'd1;
      end else idx_d = idx_q + 11'd1;
    end else if (state_q == ST_GAP) begin
      gcnt_d = gcnt_q + 8'd1;
      if (gcnt_q == gap_q) begin
        frame_cnt_d = frame_cnt_q + 32'd1;
        seq_d = seq_q + 32'd1;
        sent_d = sent_q + 16'd1;
        // Leaving GAP evaluates the start condition at once so back-to-back gaps are exactly ifg.
        if (burst_q != 16'd0 && sent_d == burst_q) state_d = ST_DONE;
        else begin
          state_d = ST_IDLE;
          try_start = 1'b1;
        end
      end
    end else if (state_q == ST_DONE) begin
      if (!gen_en) begin
        state_d = ST_IDLE;
        sent_d = '0;
      end
    end else try_start = 1'b1;
    if (try_start) begin
      if (!gen_en) sent_d = '0;
      else if (rx.alf) holdoff_d = holdoff_q + {31'd0, ~&holdoff_q};
      else begin
        state_d = ST_SEND;
        idx_d = '0;
        len_d = clamp_len(frame_len);
        gap_d = ifg == 8'd0 ? 8'd1 : ifg;
        err_d = pend_q | err_inject;
        pend_d = 1'b0;
        burst_d = sent_d == 16'd0 ? burst_cnt : burst_q;
      end
    end
  end

  always_comb begin
    tvalid_d = state_d == ST_SEND;
    tlast_d = tvalid_d && idx_d == len_d - 11'd1;
    tuser_d = tlast_d && err_d;
    tdata_d = tvalid_d ? byte_d : 8'd0;
    busy_d = tvalid_d || state_d == ST_GAP;
    done_d = state_d == ST_DONE;
  end

  always_ff @(posedge wrclk or negedge wr_reset) begin
    if (!wr_reset) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      seq_q <= '0;
      sent_q <= '0;
      burst_q <= '0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      frame_cnt_q <= '0;
      holdoff_q <= '0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      seq_q <= seq_d;
      sent_q <= sent_d;
      burst_q <= burst_d;
      err_q <= err_d;
      pend_q <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      holdoff_q <= holdoff_d;
      tdata_q <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign rx.tdata = tdata_q;
  assign rx.tvalid = tvalid_q;
  assign rx.tlast = tlast_q;
  assign rx.tuser = tuser_q;
  assign gen_busy = busy_q;
  assign gen_done = done_q;
  assign frame_cnt = frame_cnt_q;
  assign holdoff_cnt = holdoff_q;
endmodule
